// File: rtl/dma_fifo_drain.sv
// Read-side DMA master: pops staged words from the fifo one at a time and writes
// each to consecutive memory word addresses through the openMSP430 DMA port.
module dma_fifo_drain #(
    parameter int DATA   = 16,
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic              fifo_empty,
    input  logic [DATA-1:0]   fifo_out,
    output logic              fifo_enable,
    output logic              fifo_wr_rd,
    output logic              dma_en,
    output logic [1:0]        dma_we,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [DATA-1:0]   dma_din,
    input  logic              dma_ready,
    input  logic              dma_resp
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        REQ,
        DONE,
        ERR
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [LEN_W-1:0]  rem, rem_next;
    logic [DATA-1:0]   hold, hold_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            rem   <= '0;
            hold  <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            rem   <= rem_next;
            hold  <= hold_next;
        end
    end

    // Abort is tested before the fifo pop and the ready handshake so that a
    // cancelled transfer never consumes a word nor advances the address.
    always_comb begin
        state_next  = state;
        addr_next   = addr;
        rem_next    = rem;
        hold_next   = hold;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        fifo_enable = 1'b0;
        fifo_wr_rd  = 1'b0;
        dma_en      = 1'b0;
        dma_we      = 2'b00;
        dma_addr    = '0;
        dma_din     = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    addr_next  = start_addr;
                    rem_next   = word_count;
                    state_next = (word_count == '0) ? DONE : POP;
                end
            end
            POP: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (!fifo_empty) begin
                    fifo_enable = 1'b1;
                    hold_next   = fifo_out;
                    state_next  = REQ;
                end
            end
            REQ: begin
                busy     = 1'b1;
                dma_en   = 1'b1;
                dma_we   = 2'b11;
                dma_addr = addr;
                dma_din  = hold;
                if (abort) begin
                    state_next = IDLE;
                end else if (dma_ready) begin
                    if (dma_resp) begin
                        state_next = ERR;
                    end else begin
                        addr_next  = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        rem_next   = rem - {{(LEN_W-1){1'b0}}, 1'b1};
                        state_next = (rem == {{(LEN_W-1){1'b0}}, 1'b1}) ? DONE : POP;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                error      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_fifo_drain.sv
// Self-checking bench for dma_fifo_drain: transaction-level model compared every
// cycle, plus literal expectations on the observed write stream.
module tb_dma_fifo_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [14:0] start_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, error;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_out = '0;
    logic        fifo_enable, fifo_wr_rd, dma_en;
    logic [1:0]  dma_we;
    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic        dma_ready = 1'b1;
    logic        dma_resp = 1'b0;

    dma_fifo_drain dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_addr(start_addr), .word_count(word_count),
        .busy(busy), .done(done), .error(error),
        .fifo_empty(fifo_empty), .fifo_out(fifo_out),
        .fifo_enable(fifo_enable), .fifo_wr_rd(fifo_wr_rd),
        .dma_en(dma_en), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_ready(dma_ready), .dma_resp(dma_resp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] fifo_q[$];
    logic        stall = 1'b0;

    // Transaction-level view: are we mid-transfer, do we hold a word, and
    // which completion pulse (0 none, 1 done, 2 error) is showing.
    logic        m_active = 1'b0;
    logic        m_holding = 1'b0;
    int          m_pulse = 0;
    logic [14:0] m_addr = '0;
    int          m_left = 0;
    logic [15:0] m_data = '0;

    logic [30:0] wlog[$];
    int          pops = 0;
    int          dones = 0;
    int          errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh_fifo();
        fifo_empty = stall || (fifo_q.size() == 0);
        fifo_out   = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            refresh_fifo();
            @(posedge clk);
            #1;
            refresh_fifo();
        end
    endtask

    task automatic clear_counts();
        wlog.delete();
        pops  = 0;
        dones = 0;
        errs  = 0;
    endtask

    task automatic check_write(input string name, input int idx,
                               input logic [14:0] a, input logic [15:0] d);
        logic [30:0] entry;
        entry = (idx < wlog.size()) ? wlog[idx] : 31'h7FFFFFFF;
        chk(name, {1'b0, entry}, {1'b0, a, d});
    endtask

    task automatic applyStimulus(input logic [14:0] a, input logic [15:0] n);
        start_addr = a;
        word_count = n;
        start      = 1'b1;
        cycle(1);
        start      = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  = 1'b0;
            m_holding = 1'b0;
            m_pulse   = 0;
            m_addr    = '0;
            m_left    = 0;
            m_data    = '0;
        end else if (m_pulse != 0) begin
            m_pulse = 0;
        end else if (!m_active) begin
            if (start) begin
                m_addr = start_addr;
                m_left = int'(word_count);
                if (word_count == 16'd0) m_pulse = 1;
                else begin
                    m_active  = 1'b1;
                    m_holding = 1'b0;
                end
            end
        end else if (abort) begin
            m_active  = 1'b0;
            m_holding = 1'b0;
        end else if (!m_holding) begin
            if (!fifo_empty) begin
                m_data = fifo_out;
                void'(fifo_q.pop_front());
                m_holding = 1'b1;
            end
        end else if (dma_ready) begin
            if (dma_resp) begin
                m_active  = 1'b0;
                m_holding = 1'b0;
                m_pulse   = 2;
            end else begin
                m_addr    = m_addr + 15'd1;
                m_left    = m_left - 1;
                m_holding = 1'b0;
                if (m_left == 0) begin
                    m_active = 1'b0;
                    m_pulse  = 1;
                end
            end
        end
    end

    // Record what the DUT actually did at each edge, for literal checks.
    always @(posedge clk) begin
        if (!rst) begin
            if (dma_en && dma_ready && !dma_resp && !abort) wlog.push_back({dma_addr, dma_din});
            if (fifo_enable) pops++;
            if (done) dones++;
            if (error) errs++;
        end
    end

    always @(negedge clk) begin
        logic writing;
        writing = m_active && m_holding;
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("done", {31'd0, done}, {31'd0, m_pulse == 1});
        chk("error", {31'd0, error}, {31'd0, m_pulse == 2});
        chk("fifo_enable", {31'd0, fifo_enable},
            {31'd0, m_active && !m_holding && !fifo_empty && !abort});
        chk("fifo_wr_rd", {31'd0, fifo_wr_rd}, 32'd0);
        chk("dma_en", {31'd0, dma_en}, {31'd0, writing});
        chk("dma_we", {30'd0, dma_we}, writing ? 32'd3 : 32'd0);
        chk("dma_addr", {17'd0, dma_addr}, writing ? {17'd0, m_addr} : 32'd0);
        chk("dma_din", {16'd0, dma_din}, writing ? {16'd0, m_data} : 32'd0);
    end

    initial begin
        cycle(3);
        rst = 1'b0;
        cycle(1);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // T1: four words in order, ready always high
        clear_counts();
        fifo_q = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
        applyStimulus(15'h0100, 16'd4);
        cycle(12);
        chk("t1_writes", wlog.size(), 32'd4);
        check_write("t1_w0", 0, 15'h0100, 16'h00A1);
        check_write("t1_w1", 1, 15'h0101, 16'h00B2);
        check_write("t1_w2", 2, 15'h0102, 16'h00C3);
        check_write("t1_w3", 3, 15'h0103, 16'h00D4);
        chk("t1_pops", pops, 32'd4);
        chk("t1_dones", dones, 32'd1);

        // T2: zero-length transfer
        clear_counts();
        fifo_q = '{16'h1234};
        applyStimulus(15'h0010, 16'd0);
        chk("t2_done_pulse", {31'd0, done}, 32'd1);
        cycle(1);
        chk("t2_done_clear", {31'd0, done}, 32'd0);
        cycle(3);
        chk("t2_pops", pops, 32'd0);
        chk("t2_writes", wlog.size(), 32'd0);
        fifo_q.delete();

        // T3: fifo empty for five cycles mid-transfer
        clear_counts();
        fifo_q = '{16'h00E5, 16'h00F6, 16'h0007};
        applyStimulus(15'h0200, 16'd3);
        cycle(2);
        stall = 1'b1;
        cycle(5);
        chk("t3_stall_pops", pops, 32'd1);
        stall = 1'b0;
        cycle(10);
        check_write("t3_w0", 0, 15'h0200, 16'h00E5);
        check_write("t3_w1", 1, 15'h0201, 16'h00F6);
        check_write("t3_w2", 2, 15'h0202, 16'h0007);
        chk("t3_dones", dones, 32'd1);

        // T4: ready withheld three cycles, address wraps past 0x7FFF
        clear_counts();
        fifo_q = '{16'h1111, 16'h2222};
        dma_ready = 1'b0;
        applyStimulus(15'h7FFF, 16'd2);
        cycle(4);
        chk("t4_held_en", {31'd0, dma_en}, 32'd1);
        dma_ready = 1'b1;
        cycle(8);
        check_write("t4_w0", 0, 15'h7FFF, 16'h1111);
        check_write("t4_w1", 1, 15'h0000, 16'h2222);
        chk("t4_dones", dones, 32'd1);

        // T5: error response on the second of three words
        clear_counts();
        fifo_q = '{16'h3333, 16'h4444, 16'h5555};
        applyStimulus(15'h0300, 16'd3);
        cycle(3);
        dma_resp = 1'b1;
        cycle(1);
        dma_resp = 1'b0;
        chk("t5_error_pulse", {31'd0, error}, 32'd1);
        cycle(3);
        chk("t5_errs", errs, 32'd1);
        chk("t5_dones", dones, 32'd0);
        chk("t5_pops", pops, 32'd2);
        chk("t5_writes", wlog.size(), 32'd1);
        fifo_q = '{16'h6666};
        applyStimulus(15'h0400, 16'd1);
        cycle(6);
        check_write("t5_restart", 1, 15'h0400, 16'h6666);
        chk("t5_restart_done", dones, 32'd1);

        // T6: abort in POP, then reset while a request is pending
        clear_counts();
        fifo_q = '{16'h7777, 16'h8888};
        applyStimulus(15'h0500, 16'd2);
        abort = 1'b1;
        refresh_fifo();
        #1;
        chk("t6_abort_no_pop", {31'd0, fifo_enable}, 32'd0);
        cycle(1);
        abort = 1'b0;
        chk("t6_abort_idle", {31'd0, busy}, 32'd0);
        chk("t6_abort_pops", pops, 32'd0);
        applyStimulus(15'h0500, 16'd2);
        dma_ready = 1'b0;
        cycle(1);
        chk("t6_in_req", {31'd0, dma_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_outputs",
            {11'd0, busy, done, error, fifo_enable, dma_en, dma_we, dma_addr},
            32'd0);
        chk("t6_rst_din", {16'd0, dma_din}, 32'd0);
        cycle(1);
        rst = 1'b0;
        dma_ready = 1'b1;
        fifo_q.delete();
        cycle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
